// File: rtl/four_input_aoi_gate_pkg.sv
// rtl/four_input_aoi_gate_pkg.sv - shared constants and helpers for the AOI block
`timescale 1ns/1ps
package four_input_aoi_gate_pkg;

   localparam int SYNC_STAGES_DEFAULT = 2;
   localparam int SYNC_STAGES_MIN     = 1;
   localparam int SYNC_STAGES_MAX     = 4;

   // Counter must be able to hold SYNC_STAGES+1 (the saturation value)
   function automatic int valid_cnt_width(input int stages);
      return $clog2(stages + 2);
   endfunction

endpackage

// File: rtl/four_input_aoi_gate_sync_chain.sv
// rtl/four_input_aoi_gate_sync_chain.sv - multi-bit flop-chain synchronizer with async clear
`timescale 1ns/1ps
module four_input_aoi_gate_sync_chain #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_stage [STAGES];

   // Shift the sampled input one stage per clock; every stage clears on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < STAGES; s++) begin
            r_stage[s] <= '0;
         end
      end else begin
         r_stage[0] <= i_data;
         for (int s = 1; s < STAGES; s++) begin
            r_stage[s] <= r_stage[s-1];
         end
      end
   end

   assign o_data = r_stage[STAGES-1];

endmodule

// File: rtl/four_input_aoi_gate.sv
// rtl/four_input_aoi_gate.sv - registered per-lane AND-OR-INVERT with synchronized inputs
`timescale 1ns/1ps
module four_input_aoi_gate
   import four_input_aoi_gate_pkg::*;
#(
   parameter int WIDTH       = 1,
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] e,
   output logic [WIDTH-1:0] f,
   output logic [WIDTH-1:0] g,
   output logic             out_valid
);

   localparam int                CNT_W   = valid_cnt_width(SYNC_STAGES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SYNC_STAGES + 1);
   localparam logic [CNT_W-1:0]  CNT_HI  = CNT_W'(SYNC_STAGES);

   generate
      if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync_stages
         $error("four_input_aoi_gate: SYNC_STAGES must be within 1..4");
      end
   endgenerate

   logic [WIDTH-1:0] w_a_sync;
   logic [WIDTH-1:0] w_b_sync;
   logic [WIDTH-1:0] w_c_sync;
   logic [WIDTH-1:0] w_d_sync;
   logic [WIDTH-1:0] w_e;
   logic [WIDTH-1:0] w_f;

   logic [WIDTH-1:0] r_e;
   logic [WIDTH-1:0] r_f;
   logic [WIDTH-1:0] r_g;
   logic [CNT_W-1:0] r_cnt;
   logic             r_out_valid;

   four_input_aoi_gate_sync_chain #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync_a (
      .clk(clk), .rst_n(rst_n), .i_data(a), .o_data(w_a_sync)
   );
   four_input_aoi_gate_sync_chain #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync_b (
      .clk(clk), .rst_n(rst_n), .i_data(b), .o_data(w_b_sync)
   );
   four_input_aoi_gate_sync_chain #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync_c (
      .clk(clk), .rst_n(rst_n), .i_data(c), .o_data(w_c_sync)
   );
   four_input_aoi_gate_sync_chain #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync_d (
      .clk(clk), .rst_n(rst_n), .i_data(d), .o_data(w_d_sync)
   );

   assign w_e = w_a_sync & w_b_sync;
   assign w_f = w_c_sync & w_d_sync;

   // Capture e/f/g together from one synchronized input set so g == ~(e|f) always holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_e <= '0;
         r_f <= '0;
         r_g <= '1;
      end else begin
         r_e <= w_e;
         r_f <= w_f;
         r_g <= ~(w_e | w_f);
      end
   end

   // Count edges after release; valid rises on the edge that first delivers sampled data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         r_out_valid <= (r_cnt >= CNT_HI);
      end
   end

   assign e         = r_e;
   assign f         = r_f;
   assign g         = r_g;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_four_input_aoi_gate.sv
// tb/tb_four_input_aoi_gate.sv - self-checking bench for four_input_aoi_gate
`timescale 1ns/1ps
module tb_four_input_aoi_gate;

   localparam int W  = 4;
   localparam int SS = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] a = '0, b = '0, c = '0, d = '0;
   logic [W-1:0] e, f, g;
   logic         out_valid;

   int errors = 0;
   int checks = 0;

   four_input_aoi_gate #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst_n(rst_n),
      .a(a), .b(b), .c(c), .d(d),
      .e(e), .f(f), .g(g), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   // Reference: outputs after an edge reflect the input set seen SS edges earlier
   logic [4*W-1:0] hist [$];
   logic [4*W-1:0] cur;
   logic [W-1:0]   exp_e = '0, exp_f = '0, exp_g = '1;
   logic           exp_valid = 1'b0;
   int             m_edges = 0;

   initial begin
      for (int i = 0; i < SS; i++) hist.push_back('0);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist.delete();
         for (int i = 0; i < SS; i++) hist.push_back('0);
         exp_e = '0; exp_f = '0; exp_g = '1; exp_valid = 1'b0;
         m_edges = 0;
      end else begin
         cur = hist.pop_front();
         exp_e = cur[4*W-1:3*W] & cur[3*W-1:2*W];
         exp_f = cur[2*W-1:W] & cur[W-1:0];
         exp_g = ~(exp_e | exp_f);
         hist.push_back({a, b, c, d});
         if (m_edges < 1000) m_edges++;
         exp_valid = (m_edges >= SS + 1);
      end
   end

   task automatic test_reset();
      a = '1; b = '1; c = '1; d = '1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (e !== '0 || f !== '0 || g !== '1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: e=%h f=%h g=%h v=%b, want e=0 f=0 g=f v=0", e, f, g, out_valid);
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== (k >= SS + 1) || e !== exp_e || f !== exp_f || g !== exp_g) begin
            errors++;
            $display("FAIL reset_release k=%0d: e=%h f=%h g=%h v=%b, want e=%h f=%h g=%h v=%b",
                     k, e, f, g, out_valid, exp_e, exp_f, exp_g, (k >= SS + 1));
         end
      end
   endtask

   task automatic test_sweep();
      for (int v = 0; v < 16; v++) begin
         logic [3:0] vv;
         logic       gb;
         vv = v[3:0];
         a = {W{vv[3]}}; b = {W{vv[2]}}; c = {W{vv[1]}}; d = {W{vv[0]}};
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (e !== exp_e || f !== exp_f || g !== exp_g) begin
               errors++;
               $display("FAIL sweep_model v=%b k=%0d: e=%h f=%h g=%h, want e=%h f=%h g=%h",
                        vv, k, e, f, g, exp_e, exp_f, exp_g);
            end
         end
         gb = !((vv[3] & vv[2]) | (vv[1] & vv[0]));
         checks++;
         if (e !== {W{vv[3] & vv[2]}} || f !== {W{vv[1] & vv[0]}} || g !== {W{gb}}) begin
            errors++;
            $display("FAIL sweep_settled v=%b: e=%h f=%h g=%h, want g=%h", vv, e, f, g, {W{gb}});
         end
      end
   endtask

   task automatic test_latency();
      a = '0; b = '0; c = '0; d = '0;
      repeat (4) @(negedge clk);
      a = '1; b = '1;
      for (int k = 1; k <= SS + 1; k++) begin
         @(negedge clk);
         checks++;
         if (e !== ((k == SS + 1) ? '1 : '0) || g !== ((k == SS + 1) ? '0 : '1)) begin
            errors++;
            $display("FAIL latency k=%0d: e=%h g=%h, want e=%h g=%h", k, e, g,
                     (k == SS + 1) ? 4'hf : 4'h0, (k == SS + 1) ? 4'h0 : 4'hf);
         end
      end
   endtask

   task automatic test_lanes();
      a = 4'b1010; b = 4'b1100; c = 4'b0001; d = 4'b0011;
      repeat (SS + 1) @(negedge clk);
      checks++;
      if (e !== 4'b1000 || f !== 4'b0001 || g !== 4'b0110) begin
         errors++;
         $display("FAIL lanes: e=%b f=%b g=%b, want e=1000 f=0001 g=0110", e, f, g);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         checks++;
         if (e !== exp_e || f !== exp_f || g !== exp_g || out_valid !== exp_valid) begin
            errors++;
            $display("FAIL random n=%0d: e=%h f=%h g=%h v=%b, want e=%h f=%h g=%h v=%b",
                     n, e, f, g, out_valid, exp_e, exp_f, exp_g, exp_valid);
         end
         a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
      end
   endtask

   task automatic test_async_reset();
      a = '1; b = '1; c = '0; d = '0;
      repeat (4) @(negedge clk);
      checks++;
      if (e !== '1 || g !== '0) begin
         errors++;
         $display("FAIL async_pre: e=%h g=%h, want e=f g=0", e, g);
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (e !== '0 || f !== '0 || g !== '1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_assert: e=%h f=%h g=%h v=%b, want e=0 f=0 g=f v=0", e, f, g, out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= SS + 1; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== (k == SS + 1)) begin
            errors++;
            $display("FAIL async_valid k=%0d: v=%b want %b", k, out_valid, (k == SS + 1));
         end
      end
   endtask

   task automatic test_invariant();
      fork
         repeat (100) begin #1 a = W'($urandom); end
         repeat (50)  begin #2 b = W'($urandom); end
         repeat (25)  begin #4 c = W'($urandom); end
         repeat (12)  begin #8 d = W'($urandom); end
         for (int n = 0; n < 18; n++) begin
            @(negedge clk);
            checks++;
            if (g !== ~(e | f)) begin
               errors++;
               $display("FAIL invariant n=%0d: e=%h f=%h g=%h, want g=%h", n, e, f, g, ~(e | f));
            end
         end
      join
      @(negedge clk);
      a = '0; b = '1; c = '1; d = '1;
      repeat (SS + 2) @(negedge clk);
      checks++;
      if (e !== exp_e || f !== exp_f || g !== exp_g || f !== '1) begin
         errors++;
         $display("FAIL invariant_settle: e=%h f=%h g=%h, want e=%h f=%h g=%h", e, f, g, exp_e, exp_f, exp_g);
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_latency();
      test_lanes();
      test_random();
      test_async_reset();
      test_invariant();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
